// File: rtl/cpu_run_ctrl.sv
// Run controller and result monitor for the single-cycle MIPS core: it holds the core in
// reset for a counted number of cycles, then detects a halt or a timeout and signs ALU results.
module cpu_run_ctrl #(
  parameter int unsigned                DATA_W       = 16,
  parameter int unsigned                ADDR_W       = 16,
  parameter int unsigned                RESET_CYCLES = 5,
  parameter int unsigned                HALT_STABLE  = 4,
  parameter int unsigned                TIMEOUT      = 1024,
  parameter int unsigned                CNT_W        = 32,
  parameter int unsigned                SIG_W        = 32,
  parameter logic        [SIG_W-1:0]    SIG_SEED     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] result_in,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W-1:0] last_pc,
  output logic [SIG_W-1:0]  signature
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned STAB_W = $clog2(HALT_STABLE + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STAB_W-1:0] STABLE_LIM = STAB_W'(HALT_STABLE);
  localparam logic [CNT_W-1:0]  CNT_LIM    = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_t;

  state_t              state, next_state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [STAB_W-1:0]   stable_cnt;
  logic [ADDR_W-1:0]   prev_pc;
  logic                run_first;

  logic [STAB_W-1:0]   stable_next;
  logic [CNT_W-1:0]    cycle_next;
  logic                halt_hit;
  logic                timeout_hit;
  logic                run_begin;

  // Per-edge RUN bookkeeping; the first RUN cycle has no previous PC to compare against.
  always_comb begin
    cycle_next = cycle_count + CNT_W'(1);
    if (run_first || pc_in != prev_pc)
      stable_next = '0;
    else if (stable_cnt == STABLE_LIM)
      stable_next = stable_cnt;
    else
      stable_next = stable_cnt + STAB_W'(1);
    halt_hit    = (stable_next == STABLE_LIM);
    timeout_hit = (cycle_next == CNT_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_TIMEOUT:
          if (start) next_state = ST_RST_HOLD;
        ST_RST_HOLD:
          if (hold_cnt == HOLD_LAST) next_state = ST_RUN;
        ST_RUN:
          if (halt_hit)         next_state = ST_DONE;
          else if (timeout_hit) next_state = ST_TIMEOUT;
        default:
          next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_reset = (state != ST_RUN);
    busy      = (state == ST_RST_HOLD) || (state == ST_RUN);
    done      = (state == ST_DONE);
    timeout   = (state == ST_TIMEOUT);
  end

  assign run_begin = (state != ST_RST_HOLD) && (next_state == ST_RST_HOLD);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt    <= '0;
      stable_cnt  <= '0;
      prev_pc     <= '0;
      run_first   <= 1'b0;
      cycle_count <= '0;
      last_pc     <= '0;
      signature   <= SIG_SEED;
    end else if (run_begin) begin
      hold_cnt    <= '0;
      stable_cnt  <= '0;
      run_first   <= 1'b1;
      cycle_count <= '0;
      signature   <= SIG_SEED;
    end else if (state == ST_RST_HOLD) begin
      if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HOLD_W'(1);
    end else if (state == ST_RUN && !abort) begin
      cycle_count <= cycle_next;
      signature   <= {signature[SIG_W-2:0], signature[SIG_W-1]} ^ SIG_W'(result_in);
      prev_pc     <= pc_in;
      stable_cnt  <= stable_next;
      run_first   <= 1'b0;
      if (halt_hit || timeout_hit) last_pc <= pc_in;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a vector table for the halt and signature runs,
// plus hand-written timeout, halt-at-timeout-edge and mid-run reset sequences.
module tb_cpu_run_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] pc_in;
  logic [15:0] result_in;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;
  logic [15:0] last_pc;
  logic [31:0] signature;

  int checks   = 0;
  int failures = 0;

  cpu_run_ctrl #(
    .DATA_W(16), .ADDR_W(16), .RESET_CYCLES(5), .HALT_STABLE(4),
    .TIMEOUT(TMO), .CNT_W(32), .SIG_W(32), .SIG_SEED(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pc_in(pc_in), .result_in(result_in),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .last_pc(last_pc), .signature(signature)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        abort;
    logic [15:0] pc;
    logic [15:0] res;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        tmo;
    logic [31:0] cnt;
    logic        chk_pc;
    logic [15:0] last_pc;
    logic [31:0] sig;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic ab, input logic [15:0] pc, input logic [15:0] res,
                     input logic cr, input logic bz, input logic dn, input logic tm,
                     input logic [31:0] cnt, input logic cp, input logic [15:0] lp,
                     input logic [31:0] sig);
    vec_t v;
    v.start = st; v.abort = ab; v.pc = pc; v.res = res;
    v.cpu_reset = cr; v.busy = bz; v.done = dn; v.tmo = tm;
    v.cnt = cnt; v.chk_pc = cp; v.last_pc = lp; v.sig = sig;
    vecs.push_back(v);
  endtask

  task automatic check_ctrl(input string tag, input logic cr, input logic bz,
                            input logic dn, input logic tm);
    check({tag, ".cpu_reset"}, 64'(cpu_reset), 64'(cr));
    check({tag, ".busy"},      64'(busy),      64'(bz));
    check({tag, ".done"},      64'(done),      64'(dn));
    check({tag, ".timeout"},   64'(timeout),   64'(tm));
  endtask

  // Pulse start from a non-busy state and step through the five reset-hold cycles into RUN.
  task automatic begin_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] sig_model;
    logic [15:0] pc_v;

    reset = 1'b0; start = 1'b0; abort = 1'b0; pc_in = '0; result_in = '0;

    // Reset and idle
    #1;
    check_ctrl("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst.cnt", 64'(cycle_count), 64'd0);
    check("rst.last_pc", 64'(last_pc), 64'd0);
    check("rst.sig", 64'(signature), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_ctrl("idle", 1'b1, 1'b0, 1'b0, 1'b0);
    check("idle.cnt", 64'(cycle_count), 64'd0);
    check("idle.sig", 64'(signature), 64'd0);

    // Run 1: reset hold then halt on a PC self-loop (start ignored while in hold)
    add(1, 0, 16'd0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 16'd0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd0, 0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 16'd2, 16'd0, 0, 1, 0, 0, 2, 0, 0, 0);
    add(0, 0, 16'd4, 16'd0, 0, 1, 0, 0, 3, 0, 0, 0);
    add(0, 0, 16'd6, 16'd0, 0, 1, 0, 0, 4, 0, 0, 0);
    add(0, 0, 16'd6, 16'd0, 0, 1, 0, 0, 5, 0, 0, 0);
    add(0, 0, 16'd6, 16'd0, 0, 1, 0, 0, 6, 0, 0, 0);
    add(0, 0, 16'd6, 16'd0, 0, 1, 0, 0, 7, 0, 0, 0);
    add(0, 0, 16'd6, 16'd0, 1, 0, 1, 0, 8, 1, 16'd6, 0);
    add(0, 0, 16'd9, 16'h55, 1, 0, 1, 0, 8, 1, 16'd6, 0);
    // Run 2: restart from DONE, signature 1,3,7, start ignored in RUN, abort keeps results
    add(1, 0, 16'd0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 16'd0, 16'd1, 0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 0, 16'd2, 16'd1, 0, 1, 0, 0, 2, 0, 0, 3);
    add(0, 0, 16'd4, 16'd1, 0, 1, 0, 0, 3, 0, 0, 7);
    add(1, 0, 16'd6, 16'd0, 0, 1, 0, 0, 4, 0, 0, 14);
    add(0, 1, 16'd8, 16'd5, 1, 0, 0, 0, 4, 0, 0, 14);
    add(0, 0, 16'd10, 16'd3, 1, 0, 0, 0, 4, 0, 0, 14);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      start = vecs[i].start; abort = vecs[i].abort;
      pc_in = vecs[i].pc;    result_in = vecs[i].res;
      @(posedge clk); #1;
      check_ctrl(tag, vecs[i].cpu_reset, vecs[i].busy, vecs[i].done, vecs[i].tmo);
      check({tag, ".cnt"}, 64'(cycle_count), 64'(vecs[i].cnt));
      check({tag, ".sig"}, 64'(signature), 64'(vecs[i].sig));
      if (vecs[i].chk_pc) check({tag, ".last_pc"}, 64'(last_pc), 64'(vecs[i].last_pc));
    end
    start = 1'b0; abort = 1'b0;

    // Timeout: PC advances by 2 every RUN cycle, never halts
    begin_run();
    check_ctrl("tmo.run", 1'b0, 1'b1, 1'b0, 1'b0);
    sig_model = '0;
    for (int k = 1; k <= TMO; k++) begin
      pc_in = 16'(2 * (k - 1));
      result_in = 16'(k * 3);
      sig_model = {sig_model[30:0], sig_model[31]} ^ {16'h0, result_in};
      @(posedge clk); #1;
      if (k == TMO - 1) check_ctrl("tmo.edge15", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_ctrl("tmo.end", 1'b1, 1'b0, 1'b0, 1'b1);
    check("tmo.cnt", 64'(cycle_count), 64'(TMO));
    check("tmo.last_pc", 64'(last_pc), 64'd30);
    check("tmo.sig", 64'(signature), 64'(sig_model));

    // Halt lands on the same edge that would time out: DONE must win
    begin_run();
    pc_v = '0;
    for (int k = 1; k <= TMO; k++) begin
      if (k <= 12) pc_v = 16'(2 * (k - 1));
      pc_in = pc_v;
      result_in = '0;
      @(posedge clk); #1;
    end
    check_ctrl("h16", 1'b1, 1'b0, 1'b1, 1'b0);
    check("h16.cnt", 64'(cycle_count), 64'(TMO));
    check("h16.last_pc", 64'(last_pc), 64'd22);

    // Reset asserted mid-run clears everything without waiting for a clock edge
    begin_run();
    for (int k = 1; k <= 3; k++) begin
      pc_in = 16'(4 * k);
      result_in = 16'h00F0;
      @(posedge clk); #1;
    end
    check("mid.cnt_pre", 64'(cycle_count), 64'd3);
    #2 reset = 1'b0;
    #1;
    check_ctrl("mid.rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check("mid.cnt", 64'(cycle_count), 64'd0);
    check("mid.last_pc", 64'(last_pc), 64'd0);
    check("mid.sig", 64'(signature), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_ctrl("mid.idle", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run controller and result monitor for the parametrised single-cycle MIPS core. It replaces fixed-delay reset stimulus with a counted reset hold. It watches the core's PC and ALU result, detects the program halt (PC stuck at a self-loop), and enforces a cycle timeout. It accumulates a rotate-XOR signature of ALU results so a bench or FPGA top can check a whole program run against one golden value.

Parameters:
DATA_W, 16, width of ALU result input
ADDR_W, 16, width of PC input
RESET_CYCLES, 5, cycles cpu_reset held high after start (>=1)
HALT_STABLE, 4, consecutive repeated-PC cycles that declare halt (>=1)
TIMEOUT, 1024, max RUN cycles before timeout (>=2)
CNT_W, 32, width of cycle counter
SIG_W, 32, signature width (>=DATA_W)
SIG_SEED, 0, signature value loaded at each run start

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
start  in  1  one-cycle pulse; begins a run from IDLE, DONE or TIMEOUT
abort  in  1  forces IDLE from any state
pc_in  in  ADDR_W  core PC
result_in  in  DATA_W  core ALU result
cpu_reset  out  1  active-high reset driven to the core
busy  out  1  high in RST_HOLD and RUN
done  out  1  high in DONE
timeout  out  1  high in TIMEOUT
cycle_count  out  CNT_W  RUN cycles elapsed
last_pc  out  ADDR_W  PC at halt or timeout
signature  out  SIG_W  accumulated result signature

Behaviour:
- Reset (reset=0, async): state IDLE, cpu_reset=1, busy=0, done=0, timeout=0, cycle_count=0, last_pc=0, signature=SIG_SEED, internal counters 0.
- Outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- IDLE: cpu_reset=1. On start=1 the next state is RST_HOLD; hold counter=0, cycle_count=0, signature=SIG_SEED, stable count=0.
- RST_HOLD: cpu_reset=1 for exactly RESET_CYCLES cycles, then RUN. start is ignored.
- RUN: cpu_reset=0. At each edge:
  - cycle_count += 1.
  - signature <= rotl1(signature) ^ zero_ext(result_in).
  - On the first RUN cycle: prev_pc <= pc_in and stable=0.
  - On later cycles: stable <= (pc_in==prev_pc) ? stable+1 : 0, and prev_pc <= pc_in.
- Halt: when stable would reach HALT_STABLE at an edge, go to DONE and set last_pc <= pc_in. That cycle is counted and folded into the signature.
- Timeout: when cycle_count would reach TIMEOUT at an edge without halt, go to TIMEOUT and set last_pc <= pc_in.
- Halt and timeout on the same edge: DONE wins.
- DONE / TIMEOUT: cpu_reset=1 and all result outputs are frozen. start begins a new run, going to RST_HOLD and clearing counters and signature.
- start is ignored while busy. abort has priority over start and returns to IDLE. abort does not clear results; the next start clears them.
- Counters saturate: cycle_count never wraps because TIMEOUT < 2^CNT_W. stable saturates at HALT_STABLE.
- A reset assertion mid-run aborts immediately and asynchronously, to the reset values.

Test Plan:
- Reset then idle: reset low 3 cycles, then high with no start -> cpu_reset=1, busy=0, done=0, cycle_count=0, signature=0 indefinitely.
- Reset hold: start pulse at edge 0 -> busy=1 from edge 1; cpu_reset=1 through edge 5; cpu_reset=0 after edge 6 (RESET_CYCLES=5).
- Halt detect: pc_in per RUN cycle 0,2,4,6,6,6,6,6, result_in=0 -> done=1 after the 8th RUN edge; cycle_count=8, last_pc=6, signature=0, cpu_reset=1.
- Signature: SIG_SEED=0, result_in=0x0001 for 3 RUN cycles -> signature 1, 3, 7.
- Timeout: TIMEOUT=16, PC increments by 2 every cycle -> timeout=1 after 16 RUN edges; cycle_count=16, last_pc=30, done=0.
- Priority cases:
  - abort mid-RUN -> IDLE next edge, busy=0.
  - start during RUN -> ignored.
  - halt on edge 16 with TIMEOUT=16 -> done=1, timeout=0.
  - reset low mid-RUN -> immediate reset values.
